alu_trace_fifo: RTL and testbench
=================================

ALU_TRACE_FIFO -- requirements
Module: alu_trace_fifo

Interface
REQ-001 Parameter DEPTH, default 8, number of trace entries; power of two, 2..64.
REQ-002 Parameter EXEC_STATE, default 4'd4, control-unit state code in which the ALU result is valid.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 ResetN  input  1  asynchronous, active-low reset.
REQ-005 State  input  4  current control-unit state from the processor.
REQ-006 PC_In  input  7  processor program counter.
REQ-007 IR_In  input  16  processor instruction register.
REQ-008 ALU_In  input  16  processor ALU result.
REQ-009 Clear  input  1  synchronous flush of the FIFO and flags.
REQ-010 Rd_En  input  1  pop request from the consumer.
REQ-011 Rd_Valid  output  1  Rd_PC/Rd_IR/Rd_ALU hold a popped entry this cycle.
REQ-012 Rd_PC  output  7  popped PC.
REQ-013 Rd_IR  output  16  popped instruction.
REQ-014 Rd_ALU  output  16  popped ALU result.
REQ-015 Count  output  7  number of stored entries, 0..DEPTH.
REQ-016 Empty  output  1  Count == 0.
REQ-017 Full  output  1  Count == DEPTH.
REQ-018 Overflow  output  1  sticky: at least one capture dropped since last reset/Clear.

Function
REQ-019 Capture event SHALL be State == EXEC_STATE while the previous-cycle registered State != EXEC_STATE; one capture per entry into EXEC_STATE, regardless of dwell time.
REQ-020 On a capture event the block SHALL push {PC_In, IR_In, ALU_In} sampled in that same cycle.
REQ-021 Push while not Full SHALL write the entry and increment Count next cycle.
REQ-022 Push while Full with no accepted pop SHALL drop the entry, leave storage unchanged and set Overflow next cycle.
REQ-023 Rd_En while not Empty SHALL pop the oldest entry; Rd_PC/Rd_IR/Rd_ALU SHALL be registered and Rd_Valid SHALL be 1 for exactly the following cycle (latency 1).
REQ-024 Rd_En while Empty SHALL be ignored; Rd_Valid 0 next cycle, data outputs hold last value.
REQ-025 Simultaneous accepted pop and push (including when Full) SHALL both succeed; Count unchanged; no Overflow.
REQ-026 Simultaneous push and pop when Empty SHALL accept only the push; the pop is ignored (no bypass).
REQ-027 Read/write pointers SHALL wrap modulo DEPTH; order strictly first-in first-out.
REQ-028 Clear SHALL take priority over push and pop in the same cycle: Count 0, pointers 0, Overflow 0, Rd_Valid 0 next cycle; the capture in that cycle is discarded.
REQ-029 Clear SHALL not reset the previous-State register, so an EXEC_STATE entry straddling Clear is not re-captured.
REQ-030 Empty, Full and Count SHALL be derived from registered state only (no combinational path from Rd_En or State).

Reset
REQ-031 ResetN low SHALL immediately set Count 0, pointers 0, Overflow 0, Rd_Valid 0, Rd_PC/Rd_IR/Rd_ALU 0, previous-State register 4'd0.
REQ-032 Reset asserted mid-operation SHALL discard all stored entries; no pop or push completes in a cycle where ResetN is low.
REQ-033 Storage array contents need not be reset.
REQ-034 After ResetN deassertion, the first capture SHALL occur no earlier than the first rising edge with State == EXEC_STATE.

Configuration
REQ-035 Macro TRACE_DROP_COUNT_EN defined: additional output Drop_Cnt (8 bits) SHALL count dropped captures, saturating at 255, cleared by reset and Clear.
REQ-036 TRACE_DROP_COUNT_EN undefined: Drop_Cnt port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-037 Reset, State 0->4->4->4->0, PC 5, IR 16'h2312, ALU 16'h0007 -> Count 1 after one edge, single entry; Rd_En 1 cycle -> next cycle Rd_Valid 1, Rd_PC 5, Rd_IR 16'h2312, Rd_ALU 16'h0007, Empty 1.
REQ-038 Ten distinct capture events, no reads -> Full 1, Count 8, Overflow 1, Drop_Cnt 2 (macro on); eight pops return events 1..8 in order.
REQ-039 FIFO Full, capture event coincident with Rd_En -> oldest entry popped, new entry stored, Count stays 8, Overflow 0.
REQ-040 Empty FIFO, Rd_En 1 for 3 cycles -> Rd_Valid stays 0, Count 0.
REQ-041 Count 5, Clear and capture event same cycle -> Count 0, Empty 1, Overflow 0, no entry retained.
REQ-042 Count 3 with Overflow 1, ResetN pulsed low between edges -> outputs zero immediately, Empty 1 after release.

Source files
------------

// File: rtl/alu_trace_fifo.sv
// Trace FIFO capturing {PC, IR, ALU} once per entry into the execute state of a processor.
// Optional TRACE_DROP_COUNT_EN adds a saturating Drop_Cnt output counting dropped captures.
module alu_trace_fifo #(
  parameter int unsigned DEPTH      = 8,
  parameter logic [3:0]  EXEC_STATE = 4'd4
) (
  input  logic        Clk,
  input  logic        ResetN,
  input  logic [3:0]  State,
  input  logic [6:0]  PC_In,
  input  logic [15:0] IR_In,
  input  logic [15:0] ALU_In,
  input  logic        Clear,
  input  logic        Rd_En,
  output logic        Rd_Valid,
  output logic [6:0]  Rd_PC,
  output logic [15:0] Rd_IR,
  output logic [15:0] Rd_ALU,
  output logic [6:0]  Count,
  output logic        Empty,
  output logic        Full,
`ifdef TRACE_DROP_COUNT_EN
  output logic        Overflow,
  output logic [7:0]  Drop_Cnt
`else
  output logic        Overflow
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [6:0]  pc;
    logic [15:0] ir;
    logic [15:0] alu;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [6:0]      count_q;
  logic [3:0]      prev_state_q;
  logic            overflow_q;
  logic            rd_valid_q;
  entry_t          rd_data_q;

  logic capture, empty, full, pop, push, drop;

  assign empty = (count_q == 7'd0);
  assign full  = (count_q == 7'(DEPTH));

  // Edge-detect into EXEC_STATE so a long dwell yields a single capture.
  assign capture = (State == EXEC_STATE) && (prev_state_q != EXEC_STATE);
  assign pop     = Rd_En && !empty && !Clear;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still succeeds.
  assign push    = capture && !Clear && (!full || pop);
  assign drop    = capture && !Clear && full && !pop;

  always_ff @(posedge Clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{pc: PC_In, ir: IR_In, alu: ALU_In};
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      prev_state_q <= 4'd0;
      overflow_q   <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      // Not cleared by Clear: an EXEC_STATE dwell across Clear must not re-capture.
      prev_state_q <= State;
      if (Clear) begin
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        count_q    <= '0;
        overflow_q <= 1'b0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= pop;
        if (pop) begin
          rd_data_q <= mem_q[rd_ptr_q];
          rd_ptr_q  <= rd_ptr_q + AW'(1);
        end
        if (push) begin
          wr_ptr_q <= wr_ptr_q + AW'(1);
        end
        if (drop) begin
          overflow_q <= 1'b1;
        end
        unique case ({push, pop})
          2'b10:   count_q <= count_q + 7'd1;
          2'b01:   count_q <= count_q - 7'd1;
          default: count_q <= count_q;
        endcase
      end
    end
  end

`ifdef TRACE_DROP_COUNT_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      drop_cnt_q <= 8'd0;
    end else if (Clear) begin
      drop_cnt_q <= 8'd0;
    end else if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign Drop_Cnt = drop_cnt_q;
`endif

  assign Rd_Valid = rd_valid_q;
  assign Rd_PC    = rd_data_q.pc;
  assign Rd_IR    = rd_data_q.ir;
  assign Rd_ALU   = rd_data_q.alu;
  assign Count    = count_q;
  assign Empty    = empty;
  assign Full     = full;
  assign Overflow = overflow_q;

endmodule

// File: tb/tb_alu_trace_fifo.sv
// Bench for alu_trace_fifo: queue-based reference model, per-cycle compare, directed + random.
module tb_alu_trace_fifo;

  localparam int         DEPTH = 8;
  localparam logic [3:0] EXEC  = 4'd4;

  logic        Clk = 1'b0;
  logic        ResetN = 1'b0;
  logic [3:0]  State = 4'd0;
  logic [6:0]  PC_In = '0;
  logic [15:0] IR_In = '0;
  logic [15:0] ALU_In = '0;
  logic        Clear = 1'b0;
  logic        Rd_En = 1'b0;
  logic        Rd_Valid;
  logic [6:0]  Rd_PC;
  logic [15:0] Rd_IR;
  logic [15:0] Rd_ALU;
  logic [6:0]  Count;
  logic        Empty;
  logic        Full;
  logic        Overflow;
`ifdef TRACE_DROP_COUNT_EN
  logic [7:0]  Drop_Cnt;
`endif

  alu_trace_fifo #(.DEPTH(DEPTH), .EXEC_STATE(EXEC)) dut (
    .Clk      (Clk),
    .ResetN   (ResetN),
    .State    (State),
    .PC_In    (PC_In),
    .IR_In    (IR_In),
    .ALU_In   (ALU_In),
    .Clear    (Clear),
    .Rd_En    (Rd_En),
    .Rd_Valid (Rd_Valid),
    .Rd_PC    (Rd_PC),
    .Rd_IR    (Rd_IR),
    .Rd_ALU   (Rd_ALU),
    .Count    (Count),
    .Empty    (Empty),
    .Full     (Full),
`ifdef TRACE_DROP_COUNT_EN
    .Overflow (Overflow),
    .Drop_Cnt (Drop_Cnt)
`else
    .Overflow (Overflow)
`endif
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of entries plus sticky flags.
  typedef struct {
    logic [6:0]  pc;
    logic [15:0] ir;
    logic [15:0] alu;
  } ent_t;

  ent_t       q[$];
  ent_t       m_rd = '{pc: '0, ir: '0, alu: '0};
  bit         m_ov = 0;
  bit         m_rv = 0;
  int         m_drops = 0;
  logic [3:0] m_prev = 4'd0;

  always @(posedge Clk or negedge ResetN) begin : model
    bit cap;
    if (!ResetN) begin
      q.delete();
      m_rd    = '{pc: '0, ir: '0, alu: '0};
      m_ov    = 0;
      m_rv    = 0;
      m_drops = 0;
      m_prev  = 4'd0;
    end else begin
      cap    = (State == EXEC) && (m_prev != EXEC);
      m_prev = State;
      if (Clear) begin
        q.delete();
        m_ov    = 0;
        m_rv    = 0;
        m_drops = 0;
      end else begin
        m_rv = Rd_En && (q.size() > 0);
        if (m_rv) m_rd = q.pop_front();
        if (cap) begin
          if (q.size() < DEPTH) q.push_back('{pc: PC_In, ir: IR_In, alu: ALU_In});
          else begin
            m_ov = 1;
            if (m_drops < 255) m_drops++;
          end
        end
      end
    end
  end

  always @(negedge Clk) begin
    if (ResetN) begin
      chk("count",    32'(Count),    32'(q.size()));
      chk("empty",    32'(Empty),    32'(q.size() == 0));
      chk("full",     32'(Full),     32'(q.size() == DEPTH));
      chk("overflow", 32'(Overflow), 32'(m_ov));
      chk("rd_valid", 32'(Rd_Valid), 32'(m_rv));
      chk("rd_pc",    32'(Rd_PC),    32'(m_rd.pc));
      chk("rd_ir",    32'(Rd_IR),    32'(m_rd.ir));
      chk("rd_alu",   32'(Rd_ALU),   32'(m_rd.alu));
`ifdef TRACE_DROP_COUNT_EN
      chk("drop_cnt", 32'(Drop_Cnt), 32'(m_drops));
`endif
    end
  end

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic ev(input logic [6:0] pc, input logic [15:0] ir, input logic [15:0] alu);
    State = EXEC; PC_In = pc; IR_In = ir; ALU_In = alu;
    tick();
    State = 4'd0;
    tick();
  endtask

  initial begin
    repeat (2) tick();
    ResetN = 1'b1;
    tick();
    chk("rst_count", 32'(Count), 32'd0);
    chk("rst_empty", 32'(Empty), 32'd1);
    chk("rst_valid", 32'(Rd_Valid), 32'd0);

    // Single capture across a multi-cycle EXEC dwell, then one pop.
    State = EXEC; PC_In = 7'd5; IR_In = 16'h2312; ALU_In = 16'h0007;
    tick();
    chk("one_cap_count", 32'(Count), 32'd1);
    repeat (2) tick();
    State = 4'd0;
    tick();
    chk("dwell_count", 32'(Count), 32'd1);
    Rd_En = 1'b1;
    tick();
    Rd_En = 1'b0;
    chk("pop_valid", 32'(Rd_Valid), 32'd1);
    chk("pop_pc",    32'(Rd_PC),    32'd5);
    chk("pop_ir",    32'(Rd_IR),    32'h2312);
    chk("pop_alu",   32'(Rd_ALU),   32'h0007);
    chk("pop_empty", 32'(Empty),    32'd1);
    tick();
    chk("valid_one_cycle", 32'(Rd_Valid), 32'd0);

    // Ten captures into a depth-8 FIFO: two drops.
    for (int i = 1; i <= 10; i++) ev(7'(i), 16'(16'h1000 + i), 16'(16'h2000 + i));
    chk("ten_full",  32'(Full),     32'd1);
    chk("ten_count", 32'(Count),    32'd8);
    chk("ten_ovf",   32'(Overflow), 32'd1);
`ifdef TRACE_DROP_COUNT_EN
    chk("ten_drops", 32'(Drop_Cnt), 32'd2);
`endif
    for (int i = 1; i <= 8; i++) begin
      Rd_En = 1'b1;
      tick();
      chk("order_pc", 32'(Rd_PC), 32'(i));
    end
    Rd_En = 1'b0;

    // Reads on an empty FIFO are ignored.
    Rd_En = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("empty_rd_valid", 32'(Rd_Valid), 32'd0);
      chk("empty_rd_count", 32'(Count), 32'd0);
    end
    Rd_En = 1'b0;

    // Full FIFO, capture coincident with pop.
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    chk("clear_ovf", 32'(Overflow), 32'd0);
    for (int i = 1; i <= 8; i++) ev(7'(20 + i), 16'(i), 16'(i));
    State = EXEC; PC_In = 7'd99; Rd_En = 1'b1;
    tick();
    State = 4'd0; Rd_En = 1'b0;
    chk("fullpp_valid", 32'(Rd_Valid), 32'd1);
    chk("fullpp_pc",    32'(Rd_PC),    32'd21);
    chk("fullpp_count", 32'(Count),    32'd8);
    chk("fullpp_ovf",   32'(Overflow), 32'd0);
    tick();

    // Clear beats a same-cycle capture; dwell across Clear is not re-captured.
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    for (int i = 1; i <= 5; i++) ev(7'(40 + i), 16'(i), 16'(i));
    chk("five_count", 32'(Count), 32'd5);
    State = EXEC; Clear = 1'b1;
    tick();
    Clear = 1'b0;
    tick();
    chk("clr_count", 32'(Count),    32'd0);
    chk("clr_empty", 32'(Empty),    32'd1);
    chk("clr_ovf",   32'(Overflow), 32'd0);
    State = 4'd0;
    tick();

    // Count 3 with Overflow, then an asynchronous reset pulse between edges.
    for (int i = 1; i <= 9; i++) ev(7'(60 + i), 16'(i), 16'(i));
    Rd_En = 1'b1;
    repeat (5) tick();
    Rd_En = 1'b0;
    chk("pre_rst_count", 32'(Count),    32'd3);
    chk("pre_rst_ovf",   32'(Overflow), 32'd1);
    #2 ResetN = 1'b0;
    #1;
    chk("async_count", 32'(Count),    32'd0);
    chk("async_ovf",   32'(Overflow), 32'd0);
    chk("async_valid", 32'(Rd_Valid), 32'd0);
    chk("async_pc",    32'(Rd_PC),    32'd0);
    chk("async_empty", 32'(Empty),    32'd1);
    #1 ResetN = 1'b1;
    tick();
    chk("post_rst_empty", 32'(Empty), 32'd1);

    // Randomized traffic: read-light phase fills the FIFO, read-heavy phase drains it.
    for (int n = 0; n < 3000; n++) begin
      State  = ($urandom % 3 == 0) ? EXEC : 4'($urandom % 8);
      PC_In  = 7'($urandom);
      IR_In  = 16'($urandom);
      ALU_In = 16'($urandom);
      Rd_En  = (n < 1500) ? ($urandom % 8 == 0) : ($urandom % 2 == 0);
      Clear  = ($urandom % 60 == 0);
      tick();
    end
    State = 4'd0; Rd_En = 1'b0; Clear = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
